// File: rtl/dht11_poller.sv
// Schedules DHT11 start pulses (periodic or manual) with a minimum inter-read gap, supervises
// each read with timeout/retry and holds the last good humidity/temperature integer bytes.
// Latency: start 1 cycle after its condition holds; results 1 cycle after i_dht_done. Optional build macro: RANGE_CHECK_EN.
module dht11_poller #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PERIOD_MS  = 2000,
  parameter int MIN_GAP_MS = 1000,
  parameter int TIMEOUT_MS = 50,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_manual,
  input  logic        i_dht_done,
  input  logic        i_dht_valid,
  input  logic [15:0] i_humidity,
  input  logic [15:0] i_temperature,
  output logic        o_dht_start,
  output logic [7:0]  o_humidity,
  output logic [7:0]  o_temperature,
  output logic        o_data_valid,
  output logic        o_err,
  output logic        o_busy
);
  localparam int TICKS = CLK_HZ / 1000;
  localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int CW    = 16;
  localparam int RW    = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT, S_RETRY_GAP} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [TW-1:0]   r_tick;
  logic [CW-1:0]   r_period;
  logic [CW-1:0]   r_gap;
  logic [CW-1:0]   r_timeout;
  logic [RW-1:0]   r_retry;
  logic            r_pending;
  logic [7:0]      r_hum;
  logic [7:0]      r_temp;
  logic            r_dv;
  logic            r_err;

  logic            w_ms_tick;
  logic            w_gap_full;
  logic            w_good;
  logic            w_read_ok;
  logic            w_read_fail;
  logic            w_fail_final;
  logic            w_read_end;
  logic            w_unused;

  assign w_ms_tick  = (r_tick == TW'(TICKS - 1));
  assign w_gap_full = (r_gap == CW'(MIN_GAP_MS));
  assign w_read_end = w_read_ok | w_read_fail;
  // Decimal bytes are never displayed.
  assign w_unused   = ^{i_humidity[7:0], i_temperature[7:0]};

`ifdef RANGE_CHECK_EN
  assign w_good = i_dht_valid && (i_humidity[15:8] <= 8'd99) && (i_temperature[15:8] <= 8'd50);
`else
  assign w_good = i_dht_valid;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode, read evaluation strobes and state-decoded outputs.
  always_comb begin
    w_next_state = r_state;
    w_read_ok    = 1'b0;
    w_read_fail  = 1'b0;
    w_fail_final = 1'b0;
    o_dht_start  = (r_state == S_TRIG);
    o_busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (((r_period == CW'(PERIOD_MS)) || r_pending) && w_gap_full) w_next_state = S_TRIG;
      end
      S_TRIG: w_next_state = S_WAIT;
      S_WAIT: begin
        // A done in the same cycle as the timeout takes priority over the timeout.
        if (i_dht_done && w_good) begin
          w_read_ok    = 1'b1;
          w_next_state = S_IDLE;
        end else if (i_dht_done || (r_timeout == CW'(TIMEOUT_MS))) begin
          w_read_fail = 1'b1;
          if (r_retry == RW'(MAX_RETRY - 1)) begin
            w_fail_final = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_RETRY_GAP;
          end
        end
      end
      S_RETRY_GAP: begin
        if (w_gap_full) w_next_state = S_TRIG;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ms timebase and saturating period/gap/timeout counters; the timebase restarts at every
  // read end so the gap to the next start always spans whole milliseconds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick    <= '0;
      r_period  <= '0;
      r_gap     <= '0;
      r_timeout <= '0;
    end else begin
      r_tick <= (w_ms_tick || w_read_end) ? '0 : r_tick + 1'b1;
      if (w_read_ok || w_fail_final)                           r_period <= '0;
      else if (w_ms_tick && (r_period != CW'(PERIOD_MS)))      r_period <= r_period + 1'b1;
      if (w_read_end)                                          r_gap <= '0;
      else if (w_ms_tick && !w_gap_full)                       r_gap <= r_gap + 1'b1;
      if (r_state == S_TRIG)                                   r_timeout <= '0;
      else if ((r_state == S_WAIT) && w_ms_tick && (r_timeout != CW'(TIMEOUT_MS)))
        r_timeout <= r_timeout + 1'b1;
    end
  end

  // Manual request latch, retry count, error flag and held reading.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_retry   <= '0;
      r_hum     <= '0;
      r_temp    <= '0;
      r_dv      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == S_TRIG)                    r_pending <= 1'b0;
      else if ((r_state == S_IDLE) && i_manual) r_pending <= 1'b1;
      if (w_read_ok) begin
        r_hum   <= i_humidity[15:8];
        r_temp  <= i_temperature[15:8];
        r_dv    <= 1'b1;
        r_err   <= 1'b0;
        r_retry <= '0;
      end else if (w_fail_final) begin
        r_err   <= 1'b1;
        r_retry <= '0;
      end else if (w_read_fail) begin
        r_retry <= r_retry + 1'b1;
      end
    end
  end

  assign o_humidity    = r_hum;
  assign o_temperature = r_temp;
  assign o_data_valid  = r_dv;
  assign o_err         = r_err;

endmodule

// File: tb/tb_dht11_poller.sv
// Bench for dht11_poller: directed read table, hand sequences for timing corners, then
// random stimulus compared every cycle against a timestamp-based reference model.
module tb_dht11_poller;
  localparam int CLK_HZ     = 10_000;
  localparam int PERIOD_MS  = 20;
  localparam int MIN_GAP_MS = 10;
  localparam int TIMEOUT_MS = 5;
  localparam int MAX_RETRY  = 3;
  localparam int TPM        = CLK_HZ / 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_manual = 1'b0;
  logic        i_dht_done = 1'b0;
  logic        i_dht_valid = 1'b0;
  logic [15:0] i_humidity = '0;
  logic [15:0] i_temperature = '0;
  logic        o_dht_start;
  logic [7:0]  o_humidity;
  logic [7:0]  o_temperature;
  logic        o_data_valid;
  logic        o_err;
  logic        o_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  dht11_poller #(
    .CLK_HZ(CLK_HZ), .PERIOD_MS(PERIOD_MS), .MIN_GAP_MS(MIN_GAP_MS),
    .TIMEOUT_MS(TIMEOUT_MS), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .i_manual(i_manual), .i_dht_done(i_dht_done),
    .i_dht_valid(i_dht_valid), .i_humidity(i_humidity), .i_temperature(i_temperature),
    .o_dht_start(o_dht_start), .o_humidity(o_humidity), .o_temperature(o_temperature),
    .o_data_valid(o_data_valid), .o_err(o_err), .o_busy(o_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: elapsed-time bookkeeping ----------------
  localparam int M_IDLE = 0, M_START = 1, M_WAIT = 2, M_GAP = 3;
  int         m_cyc, m_base, m_ms, m_per, m_gap, m_wait, m_fails, m_mode;
  bit         m_pend, m_dv, m_err;
  logic [7:0] m_hum, m_temp;

  task automatic model_step();
    bit tick, fail, clr_all, clr_end, was_start, good;
    if (rst) begin
      m_cyc = 0; m_base = 0; m_ms = 0; m_per = 0; m_gap = 0; m_wait = 0; m_fails = 0;
      m_mode = M_IDLE; m_pend = 0; m_hum = 0; m_temp = 0; m_dv = 0; m_err = 0;
      return;
    end
    tick = ((m_cyc - m_base) % TPM) == TPM - 1;
    fail = 0; clr_all = 0; clr_end = 0;
    was_start = (m_mode == M_START);
`ifdef RANGE_CHECK_EN
    good = i_dht_valid && (i_humidity[15:8] <= 8'd99) && (i_temperature[15:8] <= 8'd50);
`else
    good = i_dht_valid;
`endif
    case (m_mode)
      M_IDLE: begin
        if (((m_ms - m_per) >= PERIOD_MS || m_pend) && (m_ms - m_gap) >= MIN_GAP_MS) m_mode = M_START;
        if (i_manual) m_pend = 1;
      end
      M_START: begin m_pend = 0; m_mode = M_WAIT; end
      M_WAIT: begin
        if (i_dht_done && good) begin
          m_hum = i_humidity[15:8]; m_temp = i_temperature[15:8];
          m_dv = 1; m_err = 0; m_fails = 0; clr_all = 1; clr_end = 1; m_mode = M_IDLE;
        end else if (i_dht_done || (m_ms - m_wait) >= TIMEOUT_MS) fail = 1;
        if (fail) begin
          m_fails++;
          clr_end = 1;
          if (m_fails >= MAX_RETRY) begin m_err = 1; m_fails = 0; clr_all = 1; m_mode = M_IDLE; end
          else m_mode = M_GAP;
        end
      end
      default: if ((m_ms - m_gap) >= MIN_GAP_MS) m_mode = M_START;
    endcase
    if (tick) m_ms++;
    m_cyc++;
    if (clr_end) begin m_gap = m_ms; m_base = m_cyc; end
    if (clr_all) m_per = m_ms;
    if (was_start) m_wait = m_ms;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en)
      check("model", {o_dht_start, o_busy, o_humidity, o_temperature, o_data_valid, o_err},
            {m_mode == M_START, m_mode != M_IDLE, m_hum, m_temp, m_dv, m_err});
  end

  // ---------------- helpers ----------------
  task automatic wait_start(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (o_dht_start === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic drive_done(input bit vld, input logic [15:0] hum, input logic [15:0] tmp);
    i_dht_done = 1; i_dht_valid = vld; i_humidity = hum; i_temperature = tmp;
    @(negedge clk);
    i_dht_done = 0; i_dht_valid = 0; i_humidity = 16'hDEAD; i_temperature = 16'hBEEF;
  endtask

  typedef struct {
    bit         tmo;
    bit         vld;
    logic [15:0] hum;
    logic [15:0] tmp;
    logic [7:0] e_hum;
    logic [7:0] e_tmp;
    bit         e_dv;
    bit         e_err;
    bit         e_busy;
    int         lo;
    int         hi;
  } vec_t;

  localparam int NV = 12;
  vec_t tv[NV];

  initial begin
    int n, t0, d;
    // lo/hi: cycles from the check point to the next start pulse
    tv[0]  = '{0, 1, 16'h2D05, 16'h1A03, 8'd45, 8'd26, 1, 0, 0, 201, 201};
    tv[1]  = '{0, 0, 16'h5555, 16'h4444, 8'd45, 8'd26, 1, 0, 1, 101, 101};
    tv[2]  = '{0, 0, 16'h5555, 16'h4444, 8'd45, 8'd26, 1, 0, 1, 101, 101};
    tv[3]  = '{0, 0, 16'h5555, 16'h4444, 8'd45, 8'd26, 1, 1, 0, 201, 201};
    tv[4]  = '{1, 0, 16'h0000, 16'h0000, 8'd45, 8'd26, 1, 1, 1, 75, 92};
    tv[5]  = '{1, 0, 16'h0000, 16'h0000, 8'd45, 8'd26, 1, 1, 1, 75, 92};
    tv[6]  = '{0, 1, 16'h3C00, 16'h1400, 8'd60, 8'd20, 1, 0, 0, 201, 201};
    tv[7]  = '{1, 0, 16'h0000, 16'h0000, 8'd60, 8'd20, 1, 0, 1, 75, 92};
    tv[8]  = '{1, 0, 16'h0000, 16'h0000, 8'd60, 8'd20, 1, 0, 1, 75, 92};
`ifdef RANGE_CHECK_EN
    tv[9]  = '{0, 1, 16'hFF00, 16'hFF00, 8'd60, 8'd20, 1, 1, 0, 201, 201};
    tv[10] = '{0, 1, 16'h6400, 16'h0500, 8'd60, 8'd20, 1, 1, 1, 101, 101};
`else
    tv[9]  = '{0, 1, 16'hFF00, 16'hFF00, 8'd255, 8'd255, 1, 0, 0, 201, 201};
    tv[10] = '{0, 1, 16'h6400, 16'h0500, 8'd100, 8'd5, 1, 0, 0, 201, 201};
`endif
    tv[11] = '{0, 1, 16'h6300, 16'h3207, 8'd99, 8'd50, 1, 0, 0, 201, 201};

    // Reset state and first periodic start.
    rst = 1;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("reset_outs", {o_dht_start, o_busy, o_humidity, o_temperature, o_data_valid, o_err}, 0);
    rst = 0;
    wait_start(400, n);
    check("reset_to_start", n, PERIOD_MS * TPM + 1);
    check("start_busy", o_busy, 1);
    @(negedge clk);
    check("start_width", o_dht_start, 0);

    // Table of reads, each following the start pulse just observed.
    for (int i = 0; i < NV; i++) begin
      if (tv[i].tmo) repeat (TIMEOUT_MS * TPM + 15) @(negedge clk);
      else begin
        repeat (2) @(negedge clk);
        drive_done(tv[i].vld, tv[i].hum, tv[i].tmp);
      end
      check($sformatf("v%0d_hum", i), o_humidity, tv[i].e_hum);
      check($sformatf("v%0d_temp", i), o_temperature, tv[i].e_tmp);
      check($sformatf("v%0d_dv", i), o_data_valid, tv[i].e_dv);
      check($sformatf("v%0d_err", i), o_err, tv[i].e_err);
      check($sformatf("v%0d_busy", i), o_busy, tv[i].e_busy);
      t0 = cyc;
      wait_start(400, n);
      d = (n > 0) ? cyc - t0 : -1;
      check($sformatf("v%0d_next_start", i), (d >= tv[i].lo && d <= tv[i].hi) ? tv[i].lo : d, tv[i].lo);
    end

    // Manual request 3 ms after a good read starts the next read at the gap, not the period.
    repeat (2) @(negedge clk);
    drive_done(1, 16'h1E00, 16'h1400);
    check("a_hum", o_humidity, 8'd30);
    t0 = cyc;
    repeat (30) @(negedge clk);
    i_manual = 1;
    @(negedge clk);
    i_manual = 0;
    wait_start(400, n);
    d = (n > 0) ? cyc - t0 : -1;
    check("manual_start", d, 101);

    // Manual request during WAIT is dropped.
    @(negedge clk);
    i_manual = 1;
    @(negedge clk);
    i_manual = 0;
    @(negedge clk);
    drive_done(1, 16'h2000, 16'h1500);
    check("b_temp", o_temperature, 8'd21);
    t0 = cyc;
    wait_start(400, n);
    d = (n > 0) ? cyc - t0 : -1;
    check("manual_in_wait", d, 201);

    // Reset in the middle of WAIT.
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rst_outs", {o_dht_start, o_busy, o_humidity, o_temperature, o_data_valid, o_err}, 0);
    rst = 0;
    wait_start(400, n);
    check("rst_to_start", n, PERIOD_MS * TPM + 1);

    // Random traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      logic [7:0] hb, tb8;
      @(negedge clk);
      hb  = 8'($urandom_range(0, 120));
      tb8 = 8'($urandom_range(0, 70));
      rst           = ($urandom_range(0, 2999) == 0);
      i_manual      = ($urandom_range(0, 99) == 0);
      i_dht_done    = ($urandom_range(0, 29) == 0);
      i_dht_valid   = ($urandom_range(0, 3) != 0);
      i_humidity    = {hb, 8'($urandom)};
      i_temperature = {tb8, 8'($urandom)};
    end
    @(negedge clk);
    rst = 0; i_manual = 0; i_dht_done = 0; i_dht_valid = 0;
    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
